// File: rtl/ex_stage.sv
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage: operand select, 32-bit ALU, branch/jump resolve,
//            registered valid/ready output. Optional 2-entry skid via EX_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage #(
    parameter int          XLEN            = 32,
    parameter logic [31:0] RESET_PC_TARGET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [3:0]      in_alu_op,
    input  logic            in_sub,
    input  logic            in_sign,
    input  logic            in_a_pc,
    input  logic            in_b_imm,
    input  logic            in_br,
    input  logic [1:0]      in_br_cond,
    input  logic            in_jal,
    input  logic            in_jalr,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target
);

    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_xor = 4'b0001;
    localparam logic [3:0] c_op_or  = 4'b0010;
    localparam logic [3:0] c_op_and = 4'b0011;
    localparam logic [3:0] c_op_sll = 4'b0100;
    localparam logic [3:0] c_op_srl = 4'b0101;
    localparam logic [3:0] c_op_sra = 4'b0110;
    localparam logic [3:0] c_op_set = 4'b1000;

    localparam logic [1:0] c_cond_eq = 2'b00;
    localparam logic [1:0] c_cond_ne = 2'b01;
    localparam logic [1:0] c_cond_lt = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            wen;
        logic            taken;
        logic [XLEN-1:0] target;
    } entry_t;

    localparam entry_t c_reset_entry = '{
        result : '0,
        rd     : '0,
        wen    : 1'b0,
        taken  : 1'b0,
        target : XLEN'(RESET_PC_TARGET)
    };

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_b_eff;
    logic [XLEN:0]   w_sum_ext;
    logic [XLEN-1:0] w_sum;
    logic            w_cf;
    logic            w_zf;
    logic            w_of;
    logic            w_lt;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_link;
    logic            w_br_cond;
    logic            w_accept;
    logic            w_in_ready;
    entry_t          w_entry;

    entry_t          r_out;
    logic            r_valid;

    assign w_op_a    = in_a_pc  ? in_pc  : in_rs1;
    assign w_op_b    = in_b_imm ? in_imm : in_rs2;
    assign w_b_eff   = in_sub ? ~w_op_b : w_op_b;
    assign w_sum_ext = {1'b0, w_op_a} + {1'b0, w_b_eff} + (XLEN + 1)'(in_sub);
    assign w_sum     = w_sum_ext[XLEN-1:0];
    assign w_cf      = w_sum_ext[XLEN];
    assign w_zf      = (w_sum == '0);
    assign w_of      = (w_op_a[XLEN-1] == w_b_eff[XLEN-1]) && (w_sum[XLEN-1] != w_op_a[XLEN-1]);
    // Unsigned less-than is a borrow, i.e. no carry out of A + ~B + 1.
    assign w_lt      = in_sign ? (w_sum[XLEN-1] ^ w_of) : !w_cf;
    assign w_shamt   = w_op_b[4:0];

    always_comb begin
        w_alu_result = '0;
        case (in_alu_op)
            c_op_add: w_alu_result = w_sum;
            c_op_xor: w_alu_result = w_op_a ^ w_op_b;
            c_op_or:  w_alu_result = w_op_a | w_op_b;
            c_op_and: w_alu_result = w_op_a & w_op_b;
            c_op_sll: w_alu_result = w_op_a << w_shamt;
            c_op_srl: w_alu_result = w_op_a >> w_shamt;
            c_op_sra: w_alu_result = $unsigned($signed(w_op_a) >>> w_shamt);
            c_op_set: w_alu_result = {{(XLEN-1){1'b0}}, w_lt};
            default:  w_alu_result = '0;
        endcase
    end

    assign w_pc_imm = in_pc + in_imm;
    assign w_link   = in_pc + XLEN'(4);

    always_comb begin
        case (in_br_cond)
            c_cond_eq: w_br_cond = w_zf;
            c_cond_ne: w_br_cond = !w_zf;
            c_cond_lt: w_br_cond = w_alu_result[0];
            default:   w_br_cond = !w_alu_result[0];
        endcase
    end

    always_comb begin
        w_entry.result = w_alu_result;
        w_entry.rd     = in_rd;
        w_entry.wen    = in_wen && !in_br && (in_rd != 5'd0);
        w_entry.taken  = 1'b0;
        w_entry.target = w_pc_imm;
        if (in_br) begin
            w_entry.taken = w_br_cond;
        end else if (in_jal) begin
            w_entry.taken  = 1'b1;
            w_entry.result = w_link;
        end else if (in_jalr) begin
            w_entry.taken  = 1'b1;
            w_entry.target = w_alu_result & ~XLEN'(1);
            w_entry.result = w_link;
        end
    end

    assign w_accept = in_valid && w_in_ready;
    assign in_ready = w_in_ready;

`ifdef EX_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;
    logic   r_in_ready;
    logic   w_out_free;

    assign w_out_free = !r_valid || out_ready;
    // in_ready is registered; only flush gates it combinationally.
    assign w_in_ready = r_in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_out        <= c_reset_entry;
            r_skid_valid <= 1'b0;
            r_skid       <= c_reset_entry;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_valid      <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out   <= w_entry;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
                r_in_ready <= 1'b1;
            end else begin
                if (w_accept) begin
                    r_skid       <= w_entry;
                    r_skid_valid <= 1'b1;
                end
                r_in_ready <= !(r_skid_valid || w_accept);
            end
        end
    end
`else
    assign w_in_ready = (!r_valid || out_ready) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= c_reset_entry;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= w_entry;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign out_valid     = r_valid;
    assign out_result    = r_out.result;
    assign out_rd        = r_out.rd;
    assign out_wen       = r_out.wen;
    assign out_br_taken  = r_out.taken;
    assign out_br_target = r_out.target;

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute pipeline stage between decode and writeback/LSU.
- Accepts one decoded instruction per valid/ready handshake and selects the ALU operands.
- Drives the 32-bit ALU combinationally, resolves branches and jumps from ALU flags/result, and registers the outcome into an output register with valid/ready handshake.
- Supports flush from the branch redirect path.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TARGET, 32'h0000_0000, reset value of out_br_target.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  drops the held output and any accepted-but-unissued entry.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  32  instruction PC.
- in_rs1  input  32  rs1 value.
- in_rs2  input  32  rs2 value.
- in_imm  input  32  sign-extended immediate.
- in_alu_op  input  4  ADD=0000, XOR=0001, OR=0010, AND=0011, SLL=0100, SRL=0101, SRA=0110, SET=1000.
- in_sub  input  1  subtract (invert B, carry-in 1).
- in_sign  input  1  signed compare.
- in_a_pc  input  1  operand A = in_pc, else in_rs1.
- in_b_imm  input  1  operand B = in_imm, else in_rs2.
- in_br  input  1  conditional branch.
- in_br_cond  input  2  00=EQ, 01=NE, 10=LT, 11=GE (signedness from in_sign).
- in_jal  input  1  JAL.
- in_jalr  input  1  JALR.
- in_rd  input  5  destination register.
- in_wen  input  1  register write enable.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts.
- out_result  output  32  writeback value.
- out_rd  output  5  destination register.
- out_wen  output  1  write enable; forced 0 when out_rd==0.
- out_br_taken  output  1  redirect required.
- out_br_target  output  32  redirect PC.

Behaviour:
- Reset: out_valid=0, out_result=0, out_rd=0, out_wen=0, out_br_taken=0, out_br_target=RESET_PC_TARGET.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, without the skid buffer.
  - Latency is 1 cycle: an accepted instruction appears on out_* the next cycle.
- ALU operands:
  - A = in_a_pc ? in_pc : in_rs1.
  - B = in_b_imm ? in_imm : in_rs2.
  - Flags (ZF, OF, CF) come from the ALU adder path and are valid for any op when in_sub=1.
- Conditional branch (decode sets in_sub=1, in_alu_op=SET, A=rs1, B=rs2):
  - EQ: taken=ZF; NE: taken=!ZF.
  - LT: taken=result[0]; GE: taken=!result[0].
  - target = in_pc + in_imm, computed by a dedicated 32-bit adder with wrap-around.
  - out_wen=0.
- JAL: taken=1, target = in_pc + in_imm, out_result = in_pc + 4.
- JALR: taken=1, target = (ALU ADD of rs1+imm) & ~32'h1, out_result = in_pc + 4.
- Otherwise: taken=0, out_result = ALU result.
- All additions are modulo 2^32 and no exception is raised.
- Output hold: out_* are stable while out_valid && !out_ready.
- Flush: out_valid clears next edge. An instruction presented in the same cycle as flush is not accepted; in_ready is forced to 0 during flush.
- Redirect: out_br_taken is meaningful only while out_valid=1; the upstream redirect must qualify it with out_valid && out_ready.
- rst mid-transfer: the held entry is discarded immediately (asynchronous).

Optional Feature:
- Macro EX_SKID_EN.
- When defined:
  - A 2-entry skid buffer is added; in_ready becomes a register, equal to the skid being empty.
  - Full throughput is sustained and no combinational path exists from out_ready to in_ready.
  - When out_ready drops with out_valid=1, the next accepted entry parks in the skid; in_ready falls the following cycle.
  - flush clears both entries.
- When undefined: single output register and combinational in_ready, as described in Behaviour.

Test Plan:
- ADD rs1=5, imm=-3 (in_b_imm=1) -> next cycle out_valid=1, out_result=2, out_br_taken=0.
- SRA rs1=32'h8000_0000, rs2=4 -> out_result=32'hF800_0000; SRL same inputs -> 32'h0800_0000.
- BLT signed rs1=-1, rs2=1, pc=32'h100, imm=32'h20 -> taken=1, target=32'h120, out_wen=0; BLTU same operands -> taken=0.
- JALR rs1=32'h2003, imm=0, pc=32'h40 -> target=32'h2002, out_result=32'h44.
- out_ready held 0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, no instruction lost or duplicated after release.
- flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming instruction not accepted; rd=0 with in_wen=1 -> out_wen=0.
